// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit custom processor: default widths,
// default program length and the fetch sequencer state encoding.
package cpu16_pkg;

    localparam int CPU_PC_W     = 8;
    localparam int CPU_INSTR_W  = 16;
    localparam int CPU_PROG_LEN = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_out_reg.sv
// One-entry valid/ready holding register for fetched instructions.
// flush beats load; load captures a new entry; ready without load drains it.
module fetch_out_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);

    logic              valid_r;
    logic [DATA_W-1:0] instr_r;
    logic [ADDR_W-1:0] pc_r;

    // Holding register: flush, load a new entry, drain on ready, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            instr_r <= '0;
            pc_r    <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
        end else if (ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign instr = instr_r;
    assign pc    = pc_r;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction
// ROM and hands fetched words to decode through a one-entry register.
// Optional feature macro: FETCH_BOUND_CHECK_EN (halt fetch at PROG_LEN).
module instr_fetch_ctrl
    import cpu16_pkg::*;
#(
    parameter int PC_W     = CPU_PC_W,
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int PROG_LEN = CPU_PROG_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_nxt_s;
    logic [15:0]       count_r;
    logic              load_cond_s;
    logic              load_s;
    logic              flush_s;
    logic              accept_s;
    logic              bound_hit_s;

    assign load_cond_s = !out_valid || out_ready;
    assign accept_s    = out_valid && out_ready;

`ifdef FETCH_BOUND_CHECK_EN
    logic halted_r;

    assign bound_hit_s = (32'(pc_r) >= 32'(PROG_LEN));

    // halted mirrors the HALT state, registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    assign halted = halted_r;
`else
    logic unused_prog_len_s;

    assign bound_hit_s       = 1'b0;
    assign unused_prog_len_s = (PROG_LEN > 0);
    assign halted            = 1'b0;
`endif

    // Next-state, next-PC, load and flush decisions; stop wins over all.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        load_s      = 1'b0;
        flush_s     = 1'b0;
        if (stop) begin
            state_nxt_s = ST_IDLE;
            flush_s     = 1'b1;
            if (redirect_valid) begin
                pc_nxt_s = redirect_pc;
            end else begin
                pc_nxt_s = pc_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        pc_nxt_s = redirect_pc;
                        flush_s  = 1'b1;
                    end else if (load_cond_s) begin
                        if (bound_hit_s) begin
                            state_nxt_s = ST_HALT;
                        end else begin
                            load_s   = 1'b1;
                            pc_nxt_s = pc_r + PC_W'(1'b1);
                        end
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        state_nxt_s = ST_FETCH;
                        pc_nxt_s    = redirect_pc;
                        flush_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_HALT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    flush_s     = 1'b1;
                end
            endcase
        end
    end

    // State and program counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Accepted-instruction counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'd0;
        end else if (accept_s && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    fetch_out_reg #(
        .DATA_W(INSTR_W),
        .ADDR_W(PC_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .load      (load_s),
        .ready     (out_ready),
        .load_instr(imem_data),
        .load_pc   (pc_r),
        .valid     (out_valid),
        .instr     (out_instr),
        .pc        (out_pc)
    );

    assign imem_addr   = pc_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed vector table, hand
// sequences for multi-cycle corners, then random stimulus against a model.
module tb_instr_fetch_ctrl;

    localparam int PROG_LEN_TB = 13;
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, out_ready, redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] rom [256];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_mode;   // 0 idle, 1 fetching, 2 halted
    logic [7:0]  m_pc;
    bit          m_valid;
    logic [7:0]  m_opc;
    logic [15:0] m_instr;
    logic [15:0] m_cnt;

    typedef struct {
        bit         s, sp, rdy, rv;
        logic [7:0] rpc;
        bit         ev;
        logic [7:0] epc;
        logic [7:0] eaddr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    instr_fetch_ctrl #(.PC_W(8), .INSTR_W(16), .PROG_LEN(PROG_LEN_TB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 8'd0; m_valid = 1'b0;
        m_opc = 8'd0; m_instr = 16'd0; m_cnt = 16'd0;
    endtask

    // One clock of the fetch rules, applied to the model's pre-edge state.
    task automatic model_step(input bit s, input bit sp, input bit rdy, input bit rv,
                              input logic [7:0] rpc);
        if (m_valid && rdy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (sp) begin
            m_mode = 0; m_valid = 1'b0;
            if (rv) m_pc = rpc;
        end else if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (rv) begin
            m_mode = 1; m_pc = rpc; m_valid = 1'b0;
        end else if (m_mode == 1) begin
            if (!m_valid || rdy) begin
                if (BOUND && int'(m_pc) >= PROG_LEN_TB) begin
                    m_mode = 2; m_valid = 1'b0;
                end else begin
                    m_opc = m_pc; m_instr = rom[m_pc]; m_valid = 1'b1;
                    m_pc = m_pc + 8'd1;
                end
            end
        end else begin
            if (rdy) m_valid = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_addr"}, 32'(imem_addr), 32'(m_pc));
        chk({tag, "_count"}, 32'(fetch_count), 32'(m_cnt));
        chk({tag, "_halted"}, 32'(halted), 32'(m_mode == 2));
        if (m_valid) begin
            chk({tag, "_outpc"}, 32'(out_pc), 32'(m_opc));
            chk({tag, "_instr"}, 32'(out_instr), 32'(m_instr));
        end
    endtask

    task automatic step(input bit s, input bit sp, input bit rdy, input bit rv,
                        input logic [7:0] rpc, input string tag);
        start = s; stop = sp; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        model_step(s, sp, rdy, rv, rpc);
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_instr"}, 32'(out_instr), 32'd0);
        chk({tag, "_outpc"}, 32'(out_pc), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_count"}, 32'(fetch_count), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
        #1;
        model_reset();
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input bit s, input bit sp, input bit rdy, input bit rv,
                                input logic [7:0] rpc, input bit ev, input logic [7:0] epc,
                                input logic [7:0] eaddr, input logic [15:0] ecnt);
        vec_t v;
        v.s = s; v.sp = sp; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
        for (int i = 0; i < 256; i++) rom[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
        rom[0] = 16'h0880;

        //            s  sp rdy rv rpc    ev epc    eaddr  ecnt
        tbl[0]  = mk(1, 0, 1, 0, 8'd0,  0, 8'd0,  8'd0,  16'd0);
        tbl[1]  = mk(0, 0, 1, 0, 8'd0,  1, 8'd0,  8'd1,  16'd0);
        tbl[2]  = mk(0, 0, 1, 0, 8'd0,  1, 8'd1,  8'd2,  16'd1);
        tbl[3]  = mk(0, 0, 1, 0, 8'd0,  1, 8'd2,  8'd3,  16'd2);
        tbl[4]  = mk(0, 0, 0, 0, 8'd0,  1, 8'd2,  8'd3,  16'd2);
        tbl[5]  = mk(0, 0, 1, 0, 8'd0,  1, 8'd3,  8'd4,  16'd3);
        tbl[6]  = mk(0, 0, 0, 1, 8'd9,  0, 8'd0,  8'd9,  16'd3);
        tbl[7]  = mk(0, 0, 0, 0, 8'd0,  1, 8'd9,  8'd10, 16'd3);
        tbl[8]  = mk(0, 0, 0, 0, 8'd0,  1, 8'd9,  8'd10, 16'd3);
        tbl[9]  = mk(0, 0, 1, 1, 8'd2,  0, 8'd0,  8'd2,  16'd4);
        tbl[10] = mk(0, 0, 1, 0, 8'd0,  1, 8'd2,  8'd3,  16'd4);
        tbl[11] = mk(0, 1, 1, 1, 8'd5,  0, 8'd0,  8'd5,  16'd5);
        tbl[12] = mk(0, 0, 1, 0, 8'd0,  0, 8'd0,  8'd5,  16'd5);
        tbl[13] = mk(0, 0, 1, 1, 8'd7,  0, 8'd0,  8'd5,  16'd5);
        tbl[14] = mk(1, 0, 0, 0, 8'd0,  0, 8'd0,  8'd5,  16'd5);
        tbl[15] = mk(0, 0, 1, 0, 8'd0,  1, 8'd5,  8'd6,  16'd5);
        tbl[16] = mk(1, 0, 1, 0, 8'd0,  1, 8'd6,  8'd7,  16'd6);
        tbl[17] = mk(0, 1, 0, 0, 8'd0,  0, 8'd0,  8'd7,  16'd6);

        // Directed vector table
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].s, tbl[i].sp, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, $sformatf("tblm%0d", i));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].eaddr));
            chk($sformatf("tbl%0d_count", i), 32'(fetch_count), 32'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_outpc", i), 32'(out_pc), 32'(tbl[i].epc));
                chk($sformatf("tbl%0d_instr", i), 32'(out_instr), 32'(rom[tbl[i].epc]));
            end
        end

        // Backpressure: first word held for four cycles
        do_reset();
        step(1, 0, 0, 0, 8'd0, "bp_start");
        step(0, 0, 0, 0, 8'd0, "bp_first");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 8'd0, "bp_hold");
            chk("bp_instr", 32'(out_instr), 32'h0880);
            chk("bp_pc", 32'(imem_addr), 32'd1);
            chk("bp_count", 32'(fetch_count), 32'd0);
        end

`ifndef FETCH_BOUND_CHECK_EN
        // PC wrap from FF to 00
        do_reset();
        step(1, 0, 1, 0, 8'd0, "wr_start");
        step(0, 0, 1, 1, 8'hFF, "wr_redir");
        chk("wr_bubble", 32'(out_valid), 32'd0);
        step(0, 0, 1, 0, 8'd0, "wr_ff");
        chk("wr_outpc_ff", 32'(out_pc), 32'hFF);
        chk("wr_addr_00", 32'(imem_addr), 32'h00);
        step(0, 0, 1, 0, 8'd0, "wr_00");
        chk("wr_outpc_00", 32'(out_pc), 32'h00);
`else
        // Bound: halt after word 12, resume by redirect
        do_reset();
        step(1, 0, 1, 0, 8'd0, "bd_start");
        step(0, 0, 1, 1, 8'd11, "bd_redir");
        step(0, 0, 1, 0, 8'd0, "bd_11");
        step(0, 0, 1, 0, 8'd0, "bd_12");
        chk("bd_outpc12", 32'(out_pc), 32'd12);
        step(0, 0, 1, 0, 8'd0, "bd_halt");
        chk("bd_halted", 32'(halted), 32'd1);
        chk("bd_valid0", 32'(out_valid), 32'd0);
        step(1, 0, 1, 0, 8'd0, "bd_start_in_halt");
        chk("bd_still_halted", 32'(halted), 32'd1);
        step(0, 0, 1, 1, 8'd0, "bd_resume");
        chk("bd_unhalted", 32'(halted), 32'd0);
        step(0, 0, 1, 0, 8'd0, "bd_pc0");
        chk("bd_outpc0", 32'(out_pc), 32'd0);
        chk("bd_instr0", 32'(out_instr), 32'h0880);
        step(0, 0, 1, 1, 8'd20, "bd_redir_far");
        chk("bd_far_not_yet", 32'(halted), 32'd0);
        step(0, 0, 1, 0, 8'd0, "bd_far_halt");
        chk("bd_far_halted", 32'(halted), 32'd1);
`endif

        // Asynchronous reset in the middle of streaming
        do_reset();
        step(1, 0, 1, 0, 8'd0, "ar_start");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'd0, "ar_run");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("ar_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bit s, sp, rdy, rv;
            logic [7:0] rpc;
            s   = ($urandom % 8) == 0;
            sp  = ($urandom % 32) == 0;
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 16) == 0;
            rpc = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 20);
            step(s, sp, rdy, rv, rpc, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
